// File: rtl/vga_pkg.sv
// Shared VGA constants and palette helpers for the sprite renderer.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef logic [2:0] pal_idx_t;

    // Each index bit drives one colour channel at full intensity: {R,G,B}.
    function automatic logic [5:0] palette_rgb(input pal_idx_t idx);
        return {{2{idx[0]}}, {2{idx[1]}}, {2{idx[2]}}};
    endfunction

endpackage

// File: rtl/sprite_motion.sv
// Per-frame sprite position, direction, colour and bounce counter.
module sprite_motion
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int SPEED    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe,
    input  logic       pause,
    output logic [9:0] x,
    output logic [9:0] y,
    output pal_idx_t   col,
    output logic [7:0] bounce_count
);

    localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - SPRITE_W);
    localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - SPRITE_H);
    localparam logic [9:0] X_INIT = 10'((H_ACTIVE - SPRITE_W) / 2);
    localparam logic [9:0] Y_INIT = 10'((V_ACTIVE - SPRITE_H) / 2);
    localparam logic [9:0] STEP   = 10'(SPEED);

    logic [9:0] x_q, x_d, y_q, y_d, x_n, y_n;
    logic       dx_q, dx_d, dy_q, dy_d, dx_n, dy_n;
    logic       hit_x, hit_y;
    pal_idx_t   col_q, col_d;
    logic [7:0] bc_q, bc_d;

    // Returns {hit, new_dir, new_pos}; the 11-bit sum keeps the upper clamp exact.
    function automatic logic [11:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] lim);
        logic [10:0] npos;
        npos = {1'b0, pos} + {1'b0, STEP};
        if (dir) begin
            if (npos >= {1'b0, lim}) axis_step = {1'b1, 1'b0, lim};
            else                     axis_step = {1'b0, 1'b1, npos[9:0]};
        end else begin
            if (pos <= STEP) axis_step = {1'b1, 1'b1, 10'd0};
            else             axis_step = {1'b0, 1'b0, pos - STEP};
        end
    endfunction

    always_comb begin
        {hit_x, dx_n, x_n} = axis_step(x_q, dx_q, X_MAX);
        {hit_y, dy_n, y_n} = axis_step(y_q, dy_q, Y_MAX);
        x_d   = x_q;
        y_d   = y_q;
        dx_d  = dx_q;
        dy_d  = dy_q;
        col_d = col_q;
        bc_d  = bc_q;
        if (strobe && !pause) begin
            x_d  = x_n;
            y_d  = y_n;
            dx_d = dx_n;
            dy_d = dy_n;
            // A corner hit is a single event.
            if (hit_x || hit_y) begin
                col_d = (col_q == 3'd7) ? 3'd1 : col_q + 3'd1;
                bc_d  = bc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q   <= X_INIT;
            y_q   <= Y_INIT;
            dx_q  <= 1'b1;
            dy_q  <= 1'b1;
            col_q <= 3'd7;
            bc_q  <= 8'd0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            col_q <= col_d;
            bc_q  <= bc_d;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign col          = col_q;
    assign bounce_count = bc_q;

endmodule

// File: rtl/sprite_bounce_renderer.sv
// Bouncing-square pixel stage: frame strobe, motion, and a 2-cycle pixel/sync pipeline.
module sprite_bounce_renderer
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter int   SPRITE_W  = 32,
    parameter int   SPRITE_H  = 32,
    parameter int   SPEED     = 2,
    parameter logic SYNC_IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       pause,
    output logic [1:0] R,
    output logic [1:0] G,
    output logic [1:0] B,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [7:0] bounce_count
);

    logic       strobe;
    logic [9:0] spr_x, spr_y, rel_x, rel_y;
    pal_idx_t   col;

    logic s1_valid_q, s1_inside_q, s1_checker_q, s1_don_q, s1_hs_q, s1_vs_q;
    logic s1_inside_d;
    logic [5:0] rgb_q, rgb_d;
    logic       hs_q, hs_d, vs_q, vs_d;

    // First line of vertical blanking: motion updates never land mid-frame.
    assign strobe = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));

    sprite_motion #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .SPRITE_W(SPRITE_W),
        .SPRITE_H(SPRITE_H),
        .SPEED   (SPEED)
    ) u_motion (
        .clk         (clk),
        .reset       (reset),
        .strobe      (strobe),
        .pause       (pause),
        .x           (spr_x),
        .y           (spr_y),
        .col         (col),
        .bounce_count(bounce_count)
    );

    always_comb begin
        rel_x       = hpos - spr_x;
        rel_y       = vpos - spr_y;
        s1_inside_d = display_on && (rel_x < 10'(SPRITE_W)) && (rel_y < 10'(SPRITE_H));
    end

    always_comb begin
        rgb_d = 6'b000000;
        hs_d  = SYNC_IDLE;
        vs_d  = SYNC_IDLE;
        if (s1_valid_q) begin
            hs_d = s1_hs_q;
            vs_d = s1_vs_q;
            if (s1_inside_q)                   rgb_d = palette_rgb(col);
            else if (s1_don_q && s1_checker_q) rgb_d = 6'b000001;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_inside_q  <= 1'b0;
            s1_checker_q <= 1'b0;
            s1_don_q     <= 1'b0;
            s1_hs_q      <= SYNC_IDLE;
            s1_vs_q      <= SYNC_IDLE;
            rgb_q        <= 6'b000000;
            hs_q         <= SYNC_IDLE;
            vs_q         <= SYNC_IDLE;
        end else begin
            s1_valid_q   <= 1'b1;
            s1_inside_q  <= s1_inside_d;
            s1_checker_q <= hpos[5] ^ vpos[5];
            s1_don_q     <= display_on;
            s1_hs_q      <= hsync_in;
            s1_vs_q      <= vsync_in;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    assign R         = rgb_q[5:4];
    assign G         = rgb_q[3:2];
    assign B         = rgb_q[1:0];
    assign hsync_out = hs_q;
    assign vsync_out = vs_q;

endmodule

// File: tb/tb_sprite_bounce_renderer.sv
// Scoreboard bench: a 640x480 instance and a 64x64 corner-hit instance on shared inputs.
module tb_sprite_bounce_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hpos = 10'd700, vpos = 10'd500;
    logic       display_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1, pause = 1'b0;

    logic [1:0] r1, g1, b1, r2, g2, b2;
    logic       hs1, vs1, hs2, vs2;
    logic [7:0] bc1, bc2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_bounce_renderer dut1 (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
        .R(r1), .G(g1), .B(b1), .hsync_out(hs1), .vsync_out(vs1), .bounce_count(bc1)
    );

    sprite_bounce_renderer #(.H_ACTIVE(64), .V_ACTIVE(64)) dut2 (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
        .R(r2), .G(g2), .B(b2), .hsync_out(hs2), .vsync_out(vs2), .bounce_count(bc2)
    );

    typedef struct {
        int         due;
        int         unit;
        bit         chk_pix;
        logic [5:0] rgb;
        logic       hs;
        logic       vs;
        bit         chk_bc;
        logic [7:0] bc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [5:0] BLACK = 6'b000000;
    localparam logic [5:0] WHITE = 6'b111111;
    localparam logic [5:0] RED   = 6'b110000;
    localparam logic [5:0] GREEN = 6'b001100;
    localparam logic [5:0] BLUE  = 6'b000001;

    task automatic push(input int delay, input int unit, input bit chk_pix, input logic [5:0] rgb,
                        input logic hs, input logic vs, input bit chk_bc, input logic [7:0] bc,
                        input string name);
        exp_t e;
        e.due = cyc + delay; e.unit = unit; e.chk_pix = chk_pix; e.rgb = rgb;
        e.hs = hs; e.vs = vs; e.chk_bc = chk_bc; e.bc = bc; e.name = name;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic don,
                         input logic hs, input logic vs, input logic pz, input logic rst);
        @(negedge clk);
        hpos = h; vpos = v; display_on = don; hsync_in = hs; vsync_in = vs;
        pause = pz; reset = rst;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(10'd700, 10'd500, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // pause is randomised here: outside the strobe cycle it must have no effect.
    task automatic probe(input int unit, input logic [9:0] h, input logic [9:0] v,
                         input logic don, input logic hs, input logic vs,
                         input logic [5:0] rgb, input string name);
        drive(h, v, don, hs, vs, 1'($urandom_range(0, 1)), 1'b0);
        push(2, unit, 1'b1, rgb, hs, vs, 1'b0, 8'd0, name);
    endtask

    task automatic strobes(input int unit, input logic pz, input int n);
        repeat (n) drive(10'd0, (unit == 1) ? 10'd480 : 10'd64, 1'b0, 1'b1, 1'b1, pz, 1'b0);
    endtask

    task automatic check_bc(input int unit, input logic [7:0] bc, input string name);
        push(1, unit, 1'b0, BLACK, 1'b1, 1'b1, 1'b1, bc, name);
    endtask

    // Monitor: compare each expectation when its output cycle arrives.
    initial begin
        exp_t       e;
        logic [5:0] a_rgb;
        logic       a_hs, a_vs;
        logic [7:0] a_bc;
        forever begin
            @(negedge clk);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e     = sb.pop_front();
                a_rgb = (e.unit == 1) ? {r1, g1, b1} : {r2, g2, b2};
                a_hs  = (e.unit == 1) ? hs1 : hs2;
                a_vs  = (e.unit == 1) ? vs1 : vs2;
                a_bc  = (e.unit == 1) ? bc1 : bc2;
                if (e.due != cyc) begin
                    n_vec++; n_err++;
                    $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.due);
                end
                if (e.chk_pix) begin
                    n_vec++;
                    if ({a_rgb, a_hs, a_vs} !== {e.rgb, e.hs, e.vs}) begin
                        n_err++;
                        $display("FAIL %s: got rgb=%b hs=%b vs=%b, want rgb=%b hs=%b vs=%b",
                                 e.name, a_rgb, a_hs, a_vs, e.rgb, e.hs, e.vs);
                    end
                end
                if (e.chk_bc) begin
                    n_vec++;
                    if (a_bc !== e.bc) begin
                        n_err++;
                        $display("FAIL %s: got bounce_count=%0d, want %0d", e.name, a_bc, e.bc);
                    end
                end
            end
        end
    end

    initial begin
        // Reset, with sync inputs low so idle outputs are distinguishable.
        repeat (3) drive(10'd304, 10'd224, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1, 1, 1'b1, BLACK, 1'b1, 1'b1, 1'b1, 8'd0, "reset_state_u1");
        push(1, 2, 1'b1, BLACK, 1'b1, 1'b1, 1'b1, 8'd0, "reset_state_u2");
        idle(2);

        // 64x64 instance: start (16,16), corner hit at (32,32) after 8 strobes.
        strobes(2, 1'b0, 7);
        check_bc(2, 8'd0, "corner_bc_before");
        strobes(2, 1'b0, 1);
        check_bc(2, 8'd1, "corner_bc_single_event");
        probe(2, 10'd32, 10'd32, 1'b1, 1'b0, 1'b1, RED,  "corner_pix_tl");
        probe(2, 10'd31, 10'd32, 1'b1, 1'b1, 1'b0, BLUE, "corner_pix_left");
        probe(2, 10'd63, 10'd63, 1'b1, 1'b0, 1'b0, RED,  "corner_pix_br");
        probe(2, 10'd32, 10'd31, 1'b1, 1'b1, 1'b1, BLUE, "corner_pix_above");
        probe(2, 10'd64, 10'd32, 1'b1, 1'b0, 1'b1, BLUE, "corner_pix_right");
        // Back down to the lower clamp: x=y=2 after 15 more, 0 and bounce on the 16th.
        strobes(2, 1'b0, 15);
        check_bc(2, 8'd1, "low_clamp_bc_before");
        strobes(2, 1'b0, 1);
        check_bc(2, 8'd2, "low_clamp_bc");
        probe(2, 10'd0,  10'd0,  1'b1, 1'b0, 1'b1, GREEN, "origin_pix");
        probe(2, 10'd31, 10'd31, 1'b1, 1'b1, 1'b0, GREEN, "origin_pix_br");
        probe(2, 10'd32, 10'd0,  1'b1, 1'b0, 1'b0, BLUE,  "origin_pix_right");
        probe(2, 10'd0,  10'd32, 1'b1, 1'b1, 1'b1, BLUE,  "origin_pix_below");

        // 640x480 instance at reset position (304,224), col 7.
        probe(1, 10'd304, 10'd224, 1'b1, 1'b0, 1'b1, WHITE, "init_tl");
        probe(1, 10'd303, 10'd224, 1'b1, 1'b1, 1'b0, BLACK, "init_left");
        probe(1, 10'd335, 10'd255, 1'b1, 1'b0, 1'b0, WHITE, "init_br");
        probe(1, 10'd336, 10'd224, 1'b1, 1'b1, 1'b1, BLUE,  "init_right");
        probe(1, 10'd304, 10'd256, 1'b1, 1'b0, 1'b1, BLUE,  "init_below");
        probe(1, 10'd310, 10'd230, 1'b0, 1'b1, 1'b0, BLACK, "init_blanked");

        strobes(1, 1'b0, 1);
        check_bc(1, 8'd0, "step1_bc");
        strobes(1, 1'b1, 1);
        check_bc(1, 8'd0, "paused_bc");
        probe(1, 10'd306, 10'd226, 1'b1, 1'b0, 1'b1, WHITE, "step1_tl");
        probe(1, 10'd305, 10'd226, 1'b1, 1'b1, 1'b1, BLACK, "step1_left");
        probe(1, 10'd338, 10'd226, 1'b1, 1'b0, 1'b0, BLUE,  "step1_right");
        probe(1, 10'd337, 10'd257, 1'b1, 1'b1, 1'b0, WHITE, "step1_br");
        probe(1, 10'd306, 10'd258, 1'b1, 1'b0, 1'b1, BLUE,  "step1_below");

        // y reaches 448 on effective strobe 112: first bounce, col 7 -> 1.
        strobes(1, 1'b0, 110);
        check_bc(1, 8'd0, "pre_ybounce_bc");
        strobes(1, 1'b0, 1);
        check_bc(1, 8'd1, "ybounce_bc");
        probe(1, 10'd528, 10'd448, 1'b1, 1'b0, 1'b1, RED,   "ybounce_tl");
        probe(1, 10'd559, 10'd479, 1'b1, 1'b1, 1'b0, RED,   "ybounce_br");
        probe(1, 10'd527, 10'd448, 1'b1, 1'b0, 1'b0, BLACK, "ybounce_left");
        probe(1, 10'd528, 10'd447, 1'b1, 1'b1, 1'b1, BLUE,  "ybounce_above");
        probe(1, 10'd560, 10'd448, 1'b1, 1'b0, 1'b1, BLUE,  "ybounce_right");

        // x reaches 608 on strobe 152 while y has fallen to 368: second bounce, col 2.
        strobes(1, 1'b0, 39);
        check_bc(1, 8'd1, "pre_xbounce_bc");
        strobes(1, 1'b0, 1);
        check_bc(1, 8'd2, "xbounce_bc");
        probe(1, 10'd608, 10'd368, 1'b1, 1'b0, 1'b1, GREEN, "xbounce_tl");
        probe(1, 10'd639, 10'd399, 1'b1, 1'b1, 1'b0, GREEN, "xbounce_br");
        probe(1, 10'd607, 10'd368, 1'b1, 1'b0, 1'b0, BLUE,  "xbounce_left");
        probe(1, 10'd608, 10'd367, 1'b1, 1'b1, 1'b1, BLACK, "xbounce_above");
        probe(1, 10'd608, 10'd400, 1'b1, 1'b0, 1'b1, BLUE,  "xbounce_below");

        strobes(1, 1'b0, 20);
        check_bc(1, 8'd2, "pre_reset_bc");
        idle(3);

        // Mid-line reset: two black/idle cycles after release, then the reset sprite.
        drive(10'd100, 10'd100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        push(1, 1, 1'b1, BLACK, 1'b1, 1'b1, 1'b1, 8'd0, "midline_reset_out");
        drive(10'd304, 10'd224, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1, 1, 1'b1, BLACK, 1'b1, 1'b1, 1'b1, 8'd0, "post_reset_black2");
        push(2, 1, 1'b1, WHITE, 1'b0, 1'b0, 1'b0, 8'd0, "post_reset_tl");
        probe(1, 10'd303, 10'd224, 1'b1, 1'b1, 1'b1, BLACK, "post_reset_left");
        probe(1, 10'd336, 10'd224, 1'b1, 1'b0, 1'b1, BLUE,  "post_reset_right");
        idle(4);

        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
